// File: rtl/mem1_pkg.sv
// Shared constants for the mem1 register-mapped peripheral: register offsets,
// CTRL/STATUS bit positions and the default window base.
package mem1_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_STATUS   = 5'h04;
    localparam logic [4:0] OFF_TIMER    = 5'h08;
    localparam logic [4:0] OFF_CMP      = 5'h0C;
    localparam logic [4:0] OFF_GPIO_OUT = 5'h10;
    localparam logic [4:0] OFF_GPIO_IN  = 5'h14;
    localparam logic [4:0] OFF_TXDATA   = 5'h18;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_FIFO_CLR = 2;

    localparam int ST_CMP_FLAG = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_EMPTY    = 2;
    localparam int ST_COUNT_LO = 3;
    localparam int ST_OVF      = 7;

    // STATUS layout: {8'h0, ovf, count[3:0], empty, full, cmp_flag}
    function automatic logic [15:0] status_word(
        input logic       cmp_flag,
        input logic       full,
        input logic       empty,
        input logic [3:0] count,
        input logic       ovf
    );
        logic [15:0] w;
        w = 16'h0000;
        w[ST_CMP_FLAG]                = cmp_flag;
        w[ST_FULL]                    = full;
        w[ST_EMPTY]                   = empty;
        w[ST_COUNT_LO +: 4]           = count;
        w[ST_OVF]                     = ovf;
        return w;
    endfunction

endpackage

// File: rtl/mem1_tx_fifo.sv
// Small register-array FIFO with a combinational head output, synchronous clear
// and a push-accepted indication so the owner can flag overflow.
module mem1_tx_fifo
    import mem1_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             push_accepted
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             pop_ok;

    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign rdata = empty ? '0 : mem_reg[rd_ptr_reg];

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign pop_ok        = pop && !empty && !clr;
    assign push_accepted = push && !clr && (!full || pop_ok);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_accepted) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop_ok)        rd_ptr_next = rd_ptr_reg + AW'(1);
            case ({push_accepted, pop_ok})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_accepted) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/mem1_peripheral.sv
// mem1 bus responder: CTRL/STATUS, prescaled compare timer, GPIO and a byte TX
// FIFO. Reads are combinational; writes and all state updates occur on clk.
module mem1_peripheral
    import mem1_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          FIFO_DEPTH = 4,
    parameter int          PRESC_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem1_ena,
    input  logic        mem1_rw,
    input  logic [31:0] mem1_daddr,
    input  logic [15:0] mem1_dout,
    output logic [15:0] mem1_din,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'h0000_001C;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

    // ---------------- decode ----------------
    logic       hit;
    logic       bus_wr;
    logic [4:0] offset;
    logic       wr_ctrl, wr_status, wr_timer, wr_cmp, wr_gpio_out, wr_txdata;

    assign hit = mem1_ena && (mem1_daddr >= BASE_ADDR) && (mem1_daddr <= LAST_ADDR)
                 && (mem1_daddr[1:0] == 2'b00);
    // Only the low five bits matter inside the window, so the subtraction stays narrow.
    assign offset = mem1_daddr[4:0] - BASE_ADDR[4:0];
    assign bus_wr = hit && mem1_rw;

    assign wr_ctrl     = bus_wr && (offset == OFF_CTRL);
    assign wr_status   = bus_wr && (offset == OFF_STATUS);
    assign wr_timer    = bus_wr && (offset == OFF_TIMER);
    assign wr_cmp      = bus_wr && (offset == OFF_CMP);
    assign wr_gpio_out = bus_wr && (offset == OFF_GPIO_OUT);
    assign wr_txdata   = bus_wr && (offset == OFF_TXDATA);

    // ---------------- registers ----------------
    logic          timer_en_reg, irq_en_reg;
    logic [15:0]   timer_reg, timer_next;
    logic [15:0]   cmp_reg;
    logic [15:0]   gpio_out_reg;
    logic [15:0]   sync1_reg, sync2_reg;
    logic          cmp_flag_reg, cmp_flag_next;
    logic          ovf_reg, ovf_next;
    logic [PW-1:0] presc_reg, presc_next;

    // ---------------- FIFO ----------------
    logic          fifo_clr, tx_pop;
    logic          fifo_full, fifo_empty, fifo_push_acc;
    logic [CW-1:0] fifo_count;
    logic [3:0]    count_field;

    assign fifo_clr = wr_ctrl && mem1_dout[CTRL_FIFO_CLR];
    assign tx_pop   = tx_valid && tx_ready;

    mem1_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk           (clk),
        .reset         (reset),
        .clr           (fifo_clr),
        .push          (wr_txdata),
        .wdata         (mem1_dout[7:0]),
        .pop           (tx_pop),
        .rdata         (tx_data),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .count         (fifo_count),
        .push_accepted (fifo_push_acc)
    );

    assign tx_valid = !fifo_empty;

    for (genvar gi = 0; gi < 4; gi++) begin : g_count_field
        if (gi < CW) begin : g_bit
            assign count_field[gi] = fifo_count[gi];
        end else begin : g_zero
            assign count_field[gi] = 1'b0;
        end
    end

    // ---------------- timer ----------------
    logic tick, timer_match, flag_set;

    assign tick        = timer_en_reg && (presc_reg == PRESC_LAST);
    assign timer_match = (timer_reg == cmp_reg);
    // A bus load of TIMER wins over a tick on the same edge and suppresses the flag.
    assign flag_set    = tick && !wr_timer && timer_match;

    always_comb begin
        presc_next = presc_reg;
        timer_next = timer_reg;
        if (wr_timer) begin
            presc_next = '0;
            timer_next = mem1_dout;
        end else if (tick) begin
            presc_next = '0;
            timer_next = timer_match ? 16'h0000 : timer_reg + 16'd1;
        end else if (timer_en_reg) begin
            presc_next = presc_reg + PW'(1);
        end
    end

    // Set beats a same-edge W1C for both sticky flags.
    always_comb begin
        cmp_flag_next = flag_set
                      | (cmp_flag_reg & ~(wr_status & mem1_dout[ST_CMP_FLAG]));
        ovf_next      = (wr_txdata && !fifo_push_acc && !fifo_clr)
                      | (ovf_reg & ~(wr_status & mem1_dout[ST_OVF]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_en_reg <= 1'b0;
            irq_en_reg   <= 1'b0;
            timer_reg    <= 16'h0000;
            cmp_reg      <= 16'hFFFF;
            gpio_out_reg <= 16'h0000;
            sync1_reg    <= 16'h0000;
            sync2_reg    <= 16'h0000;
            cmp_flag_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            presc_reg    <= '0;
        end else begin
            if (wr_ctrl) begin
                timer_en_reg <= mem1_dout[CTRL_TIMER_EN];
                irq_en_reg   <= mem1_dout[CTRL_IRQ_EN];
            end
            if (wr_cmp)      cmp_reg      <= mem1_dout;
            if (wr_gpio_out) gpio_out_reg <= mem1_dout;
            sync1_reg    <= gpio_in;
            sync2_reg    <= sync1_reg;
            timer_reg    <= timer_next;
            presc_reg    <= presc_next;
            cmp_flag_reg <= cmp_flag_next;
            ovf_reg      <= ovf_next;
        end
    end

    assign gpio_out = gpio_out_reg;
    assign irq      = irq_en_reg && cmp_flag_reg;

    // ---------------- read mux ----------------
    logic [15:0] rd_data;

    always_comb begin
        rd_data = 16'h0000;
        case (offset)
            OFF_CTRL:     rd_data = {14'h0000, irq_en_reg, timer_en_reg};
            OFF_STATUS:   rd_data = status_word(cmp_flag_reg, fifo_full, fifo_empty,
                                                count_field, ovf_reg);
            OFF_TIMER:    rd_data = timer_reg;
            OFF_CMP:      rd_data = cmp_reg;
            OFF_GPIO_OUT: rd_data = gpio_out_reg;
            OFF_GPIO_IN:  rd_data = sync2_reg;
            default:      rd_data = 16'h0000;
        endcase
    end

    assign mem1_din = (hit && !mem1_rw) ? rd_data : 16'h0000;

endmodule

// File: tb/tb_mem1_peripheral.sv
// Directed self-checking bench for mem1_peripheral: reset state, timer/irq,
// TX FIFO, GPIO, address decode misses and mid-operation reset.
module tb_mem1_peripheral;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem1_ena;
    logic        mem1_rw;
    logic [31:0] mem1_daddr;
    logic [15:0] mem1_dout;
    logic [15:0] mem1_din;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mem1_peripheral dut (
        .clk        (clk),
        .reset      (reset),
        .mem1_ena   (mem1_ena),
        .mem1_rw    (mem1_rw),
        .mem1_daddr (mem1_daddr),
        .mem1_dout  (mem1_dout),
        .mem1_din   (mem1_din),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_write(input logic [31:0] addr, input logic [15:0] data);
        @(negedge clk);
        mem1_ena   = 1'b1;
        mem1_rw    = 1'b1;
        mem1_daddr = addr;
        mem1_dout  = data;
        @(posedge clk);
        #1;
        mem1_ena = 1'b0;
        mem1_rw  = 1'b0;
        $display("wr addr=%h data=%h", addr, data);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [15:0] data);
        mem1_ena   = 1'b1;
        mem1_rw    = 1'b0;
        mem1_daddr = addr;
        #1;
        data     = mem1_din;
        mem1_ena = 1'b0;
        $display("rd addr=%h data=%h", addr, data);
    endtask

    task automatic test_reset();
        logic [15:0] offs [8] = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18, 16'h1C};
        logic [15:0] exps [8] = '{16'h0000, 16'h0004, 16'h0000, 16'hFFFF,
                                  16'h0000, 16'h0000, 16'h0000, 16'h0000};
        logic [15:0] d;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_read(BASE + 32'(offs[i]), d);
            checks++;
            if (d !== exps[i]) begin
                errors++;
                $display("FAIL reset_read_%h: got %h expected %h", offs[i], d, exps[i]);
            end
        end
        checks++;
        if ({irq, tx_valid, tx_data, gpio_out} !== 26'h0) begin
            errors++;
            $display("FAIL reset_outputs: got irq=%b tx_valid=%b tx_data=%h gpio_out=%h expected all 0",
                     irq, tx_valid, tx_data, gpio_out);
        end
    endtask

    task automatic test_timer();
        logic [15:0] d;
        bus_write(BASE + 32'h08, 16'h0000);
        bus_write(BASE + 32'h0C, 16'h0003);
        bus_write(BASE + 32'h00, 16'h0003);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            bus_read(BASE + 32'h08, d);
            checks++;
            if (d !== 16'(i)) begin
                errors++;
                $display("FAIL timer_count_%0d: got %h expected %h", i, d, 16'(i));
            end
        end
        @(posedge clk);
        bus_read(BASE + 32'h08, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL timer_wrap_on_match: got %h expected 0000", d);
        end
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 16'h0005) begin
            errors++;
            $display("FAIL timer_status_flag: got %h expected 0005", d);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL timer_irq_set: got %b expected 1", irq);
        end
        bus_write(BASE + 32'h04, 16'h0001);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL timer_irq_clear: got %b expected 0", irq);
        end
        bus_write(BASE + 32'h00, 16'h0000);
        bus_read(BASE + 32'h08, d);
        checks++;
        if (d !== 16'h0002) begin
            errors++;
            $display("FAIL timer_after_disable: got %h expected 0002", d);
        end
        @(posedge clk);
        bus_read(BASE + 32'h08, d);
        checks++;
        if (d !== 16'h0002) begin
            errors++;
            $display("FAIL timer_hold: got %h expected 0002", d);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0]  bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [15:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus_write(BASE + 32'h18, {8'h00, bytes[i]});
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 16'h0022) begin
            errors++;
            $display("FAIL fifo_full_status: got %h expected 0022", d);
        end
        bus_write(BASE + 32'h18, {8'h00, bytes[4]});
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 16'h00A2) begin
            errors++;
            $display("FAIL fifo_ovf_status: got %h expected 00a2", d);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== bytes[k]) begin
                errors++;
                $display("FAIL fifo_drain_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, tx_valid, tx_data, bytes[k]);
            end
            tx_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL fifo_empty_after_drain: got valid=%b data=%h expected valid=0 data=00",
                     tx_valid, tx_data);
        end
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 16'h0084) begin
            errors++;
            $display("FAIL fifo_ovf_sticky: got %h expected 0084", d);
        end
        bus_write(BASE + 32'h04, 16'h0080);
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL fifo_ovf_w1c: got %h expected 0004", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_bytes [4] = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
        logic [15:0] d;
        for (int i = 1; i <= 4; i++) bus_write(BASE + 32'h18, 16'h00A0 + 16'(i));
        @(negedge clk);
        tx_ready   = 1'b1;
        mem1_ena   = 1'b1;
        mem1_rw    = 1'b1;
        mem1_daddr = BASE + 32'h18;
        mem1_dout  = 16'h0066;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        mem1_ena = 1'b0;
        mem1_rw  = 1'b0;
        $display("wr addr=%h data=%h with pop", BASE + 32'h18, 16'h0066);
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 16'h0022) begin
            errors++;
            $display("FAIL b2b_status: got %h expected 0022", d);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_bytes[k]) begin
                errors++;
                $display("FAIL b2b_drain_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, tx_valid, tx_data, exp_bytes[k]);
            end
            tx_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        bus_write(BASE + 32'h18, 16'h0077);
        bus_write(BASE + 32'h18, 16'h0088);
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 16'h0010) begin
            errors++;
            $display("FAIL fifo_count2: got %h expected 0010", d);
        end
        bus_write(BASE + 32'h00, 16'h0004);
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 16'h0004 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_clr: got status=%h valid=%b expected status=0004 valid=0", d, tx_valid);
        end
        bus_read(BASE + 32'h00, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL ctrl_clr_reads_0: got %h expected 0000", d);
        end
    endtask

    task automatic test_gpio();
        logic [15:0] d;
        @(negedge clk);
        gpio_in = 16'hA5A5;
        @(posedge clk);
        bus_read(BASE + 32'h14, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL gpio_in_1cycle: got %h expected 0000", d);
        end
        @(posedge clk);
        bus_read(BASE + 32'h14, d);
        checks++;
        if (d !== 16'hA5A5) begin
            errors++;
            $display("FAIL gpio_in_2cycle: got %h expected a5a5", d);
        end
        bus_write(BASE + 32'h10, 16'h1234);
        checks++;
        if (gpio_out !== 16'h1234) begin
            errors++;
            $display("FAIL gpio_out: got %h expected 1234", gpio_out);
        end
    endtask

    task automatic test_decode_miss();
        logic [31:0] addrs [3] = '{BASE + 32'h20, 32'h0000_1002, 32'h0000_0FFC};
        logic [15:0] d;
        for (int i = 0; i < 3; i++) begin
            bus_read(addrs[i], d);
            checks++;
            if (d !== 16'h0000) begin
                errors++;
                $display("FAIL miss_read_%h: got %h expected 0000", addrs[i], d);
            end
        end
        mem1_ena   = 1'b0;
        mem1_rw    = 1'b0;
        mem1_daddr = BASE + 32'h10;
        #1;
        checks++;
        if (mem1_din !== 16'h0000) begin
            errors++;
            $display("FAIL ena0_read: got %h expected 0000", mem1_din);
        end
        bus_write(BASE + 32'h20, 16'hFFFF);
        bus_write(32'h0000_1012, 16'hFFFF);
        bus_write(32'h0000_100E, 16'h0000);
        bus_write(32'h0000_0FFC, 16'hFFFF);
        @(negedge clk);
        mem1_ena   = 1'b0;
        mem1_rw    = 1'b1;
        mem1_daddr = BASE + 32'h10;
        mem1_dout  = 16'hFFFF;
        @(posedge clk);
        #1;
        mem1_rw = 1'b0;
        checks++;
        if (gpio_out !== 16'h1234) begin
            errors++;
            $display("FAIL miss_write_gpio: got %h expected 1234", gpio_out);
        end
        bus_read(BASE + 32'h0C, d);
        checks++;
        if (d !== 16'h0003) begin
            errors++;
            $display("FAIL miss_write_cmp: got %h expected 0003", d);
        end
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL miss_write_status: got %h expected 0004", d);
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] offs [6] = '{16'h14, 16'h00, 16'h04, 16'h08, 16'h0C, 16'h10};
        logic [15:0] exps [6] = '{16'h0000, 16'h0000, 16'h0004, 16'h0000, 16'hFFFF, 16'h0000};
        logic [15:0] d;
        bus_write(BASE + 32'h00, 16'h0003);
        bus_write(BASE + 32'h18, 16'h0099);
        bus_write(BASE + 32'h18, 16'h00AA);
        @(negedge clk);
        reset      = 1'b1;
        tx_ready   = 1'b1;
        mem1_ena   = 1'b1;
        mem1_rw    = 1'b1;
        mem1_daddr = BASE + 32'h10;
        mem1_dout  = 16'hBEEF;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        tx_ready = 1'b0;
        mem1_ena = 1'b0;
        mem1_rw  = 1'b0;
        $display("reset pulse during write addr=%h data=beef", BASE + 32'h10);
        checks++;
        if ({irq, tx_valid, tx_data, gpio_out} !== 26'h0) begin
            errors++;
            $display("FAIL midop_outputs: got irq=%b tx_valid=%b tx_data=%h gpio_out=%h expected all 0",
                     irq, tx_valid, tx_data, gpio_out);
        end
        for (int i = 0; i < 6; i++) begin
            bus_read(BASE + 32'(offs[i]), d);
            checks++;
            if (d !== exps[i]) begin
                errors++;
                $display("FAIL midop_read_%h: got %h expected %h", offs[i], d, exps[i]);
            end
        end
        @(posedge clk);
        bus_read(BASE + 32'h08, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL midop_timer_hold: got %h expected 0000", d);
        end
    endtask

    initial begin
        reset      = 1'b1;
        mem1_ena   = 1'b0;
        mem1_rw    = 1'b0;
        mem1_daddr = 32'h0;
        mem1_dout  = 16'h0;
        gpio_in    = 16'h0;
        tx_ready   = 1'b0;
        test_reset();
        test_timer();
        test_fifo_overflow();
        test_back_to_back();
        test_gpio();
        test_decode_miss();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
